char_buffer_fetch: RTL and testbench
====================================

# char_buffer_fetch

Single-clock memory-read sequencer that feeds the VGA character buffer. It sweeps the text-screen region of main memory word by word over a req/ack read port and unpacks each word into individual character codes. It then emits one (row, column, code) write per cycle into the display-side character buffer. It replaces the free-running ioClk window walker with an explicit handshake, a frame counter and an inter-frame gap.

## Interface
Parameters:
- WORD_SIZE, 32, memory word width in bits.
- ASCII_SIZE, 8, bits per character slot in a word.
- CHARS_HORZ, 80, characters per text row; must be a multiple of WORD_SIZE/ASCII_SIZE.
- CHARS_VERT, 30, text rows per screen.
- VGA_MEM_OFFSET, 0, word address of screen character (0,0).
- REFRESH_GAP, 1024, idle cycles between frame sweeps; 0 is legal.

Derived:
- CPW = WORD_SIZE/ASCII_SIZE.
- WORDS = CHARS_HORZ*CHARS_VERT/CPW.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  permit sweeping; sampled only at word boundaries.
- mem_req  out  1  read request; held until mem_ack.
- mem_addr  out  WORD_SIZE  word address, stable while mem_req=1.
- mem_ack  in  1  read completion; mem_data valid in the same cycle.
- mem_data  in  WORD_SIZE  read data.
- char_we  out  1  character-buffer write strobe.
- char_row  out  $clog2(CHARS_VERT)  target row.
- char_col  out  $clog2(CHARS_HORZ)  target column.
- char_code  out  ASCII_SIZE  character code.
- frame_done  out  1  one-cycle pulse after the last character of a frame is written.
- busy  out  1  high in any state except IDLE.

## Operation
- Word w (0..WORDS-1) is read from address VGA_MEM_OFFSET + w.
- Word w covers row w/(CHARS_HORZ/CPW), starting at column (w mod (CHARS_HORZ/CPW))*CPW.
- Unpacking is MSB-first: slot k (0..CPW-1) is mem_data[WORD_SIZE-1-k*ASCII_SIZE -: ASCII_SIZE] and goes to column base+k.

FSM:
- IDLE: w=0. If enable=1, go to REQ.
- REQ: mem_req=1, mem_addr=VGA_MEM_OFFSET+w. On mem_ack=1, latch mem_data, set k=0 and go to UNPACK. mem_ack is ignored in every state other than REQ.
- UNPACK: char_we=1 every cycle, k increments each cycle. After k=CPW-1:
  - If w=WORDS-1: pulse frame_done, set w=0 and go to GAP.
  - Else if enable=0: set w=0 and go to IDLE.
  - Else: w+1 and go to REQ.
- GAP: count REFRESH_GAP cycles, then go to REQ if enable=1, else IDLE. With REFRESH_GAP=0, GAP lasts exactly one cycle.

Rules:
- enable falling mid-word never truncates a handshake or an unpack; the current word always completes.
- Row/column advance: column wraps to 0 and row increments at the end of each row. Row wraps to 0 at the frame end.
- All counters are unsigned and sized by $clog2 of their range. Address arithmetic is WORD_SIZE-bit and wraps modulo 2^WORD_SIZE.
- Reset mid-operation drops mem_req immediately and abandons any outstanding request. The memory side must tolerate mem_req falling without an ack.

## Timing
- Reset values:
  - mem_req=0, mem_addr=VGA_MEM_OFFSET.
  - char_we=0, char_row=0, char_col=0, char_code=0.
  - frame_done=0, busy=0, state IDLE.
- All outputs are registered.
- enable=1 sampled at edge E: mem_req=1 from E+1.
- mem_ack sampled at edge A: mem_req=0 from A+1. char_we=1 for cycles A+1..A+CPW, and the next mem_req rises at A+CPW+1.
- Minimum per-word period: CPW+1 cycles with zero-wait ack (ack in the first REQ cycle).
- frame_done is high in the cycle after the last char_we, coincident with GAP entry.

## Test plan
- Reset and idle: rst_n low then high with enable=0 -> all outputs stay at reset values, mem_req stays 0 for 100 cycles.
- Single word, default params: enable=1, ack on the first REQ cycle with mem_data=0x41424344 -> mem_addr=0. Writes (0,0,'A'), (0,1,'B'), (0,2,'C'), (0,3,'D') on consecutive cycles. Second mem_req appears with mem_addr=1, 5 cycles after the first.
- Row wrap: ack word 19 -> writes land on row 0, cols 76..79. Word 20 writes row 1, col 0. Ack delayed 3 cycles -> mem_addr and mem_req held stable throughout.
- Full frame with REFRESH_GAP=4, VGA_MEM_OFFSET=0x100 -> 600 requests with addresses 0x100..0x357. Exactly 2400 writes and one frame_done pulse. Next request to 0x100 follows the 4 gap cycles.
- enable dropped while waiting for an ack -> word completes all 4 writes, then busy=0 and mem_req=0. Re-enable restarts at address VGA_MEM_OFFSET and (0,0).
- Async reset asserted during UNPACK at k=2 -> char_we and mem_req go 0 immediately, with no further writes. After release and enable, the sweep restarts at word 0.

Source files
------------

// File: rtl/char_buffer_fetch_if.sv
// Memory read port and character-buffer write port of the character fetch sequencer.
interface char_buffer_fetch_if #(
    parameter int unsigned WORD_SIZE  = 32,
    parameter int unsigned ASCII_SIZE = 8,
    parameter int unsigned CHARS_HORZ = 80,
    parameter int unsigned CHARS_VERT = 30
);
    localparam int unsigned ROW_W = (CHARS_VERT > 1) ? $clog2(CHARS_VERT) : 1;
    localparam int unsigned COL_W = (CHARS_HORZ > 1) ? $clog2(CHARS_HORZ) : 1;

    logic                  mem_req;
    logic [WORD_SIZE-1:0]  mem_addr;
    logic                  mem_ack;
    logic [WORD_SIZE-1:0]  mem_data;
    logic                  char_we;
    logic [ROW_W-1:0]      char_row;
    logic [COL_W-1:0]      char_col;
    logic [ASCII_SIZE-1:0] char_code;

    // Sequencer side: issues reads, receives data, writes characters.
    modport master (
        output mem_req, mem_addr, char_we, char_row, char_col, char_code,
        input  mem_ack, mem_data
    );

    // Memory / character-buffer side.
    modport slave (
        input  mem_req, mem_addr, char_we, char_row, char_col, char_code,
        output mem_ack, mem_data
    );
endinterface

// File: rtl/char_buffer_fetch.sv
// Sweeps the text-screen region of memory word by word and unpacks each word
// into (row, column, code) writes for the VGA character buffer.
module char_buffer_fetch #(
    parameter int unsigned WORD_SIZE      = 32,
    parameter int unsigned ASCII_SIZE     = 8,
    parameter int unsigned CHARS_HORZ     = 80,
    parameter int unsigned CHARS_VERT     = 30,
    parameter int unsigned VGA_MEM_OFFSET = 0,
    parameter int unsigned REFRESH_GAP    = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    char_buffer_fetch_if.master bus,
    output logic                frame_done,
    output logic                busy
);
    localparam int unsigned CPW      = WORD_SIZE / ASCII_SIZE;
    localparam int unsigned WORDS    = (CHARS_HORZ * CHARS_VERT) / CPW;
    localparam int unsigned ROW_W    = (CHARS_VERT > 1) ? $clog2(CHARS_VERT) : 1;
    localparam int unsigned COL_W    = (CHARS_HORZ > 1) ? $clog2(CHARS_HORZ) : 1;
    localparam int unsigned WORD_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned K_W      = (CPW > 1) ? $clog2(CPW) : 1;
    // A zero gap still spends one cycle in GAP.
    localparam int unsigned GAP_LAST = (REFRESH_GAP > 0) ? REFRESH_GAP - 1 : 0;
    localparam int unsigned GAP_W    = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_UNPACK = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [WORD_W-1:0]     r_word, w_word_nxt;
    logic [K_W-1:0]        r_k, w_k_nxt;
    logic [WORD_SIZE-1:0]  r_data, w_data_nxt;
    logic [GAP_W-1:0]      r_gap, w_gap_nxt;
    logic [ROW_W-1:0]      r_pos_row, w_pos_row_nxt;
    logic [COL_W-1:0]      r_pos_col, w_pos_col_nxt;
    logic                  w_emit;
    logic [ASCII_SIZE-1:0] w_code;
    logic                  w_frame_done;

    logic                  r_mem_req;
    logic [WORD_SIZE-1:0]  r_mem_addr;
    logic                  r_char_we;
    logic [ROW_W-1:0]      r_char_row;
    logic [COL_W-1:0]      r_char_col;
    logic [ASCII_SIZE-1:0] r_char_code;
    logic                  r_frame_done;
    logic                  r_busy;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_word    <= '0;
            r_k       <= '0;
            r_data    <= '0;
            r_gap     <= '0;
            r_pos_row <= '0;
            r_pos_col <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_word    <= w_word_nxt;
            r_k       <= w_k_nxt;
            r_data    <= w_data_nxt;
            r_gap     <= w_gap_nxt;
            r_pos_row <= w_pos_row_nxt;
            r_pos_col <= w_pos_col_nxt;
        end
    end

    // Next-state logic; r_data is a shift register whose top slot is the next code.
    always_comb begin
        w_state_nxt   = r_state;
        w_word_nxt    = r_word;
        w_k_nxt       = r_k;
        w_data_nxt    = r_data;
        w_gap_nxt     = r_gap;
        w_pos_row_nxt = r_pos_row;
        w_pos_col_nxt = r_pos_col;
        w_emit        = 1'b0;
        w_code        = '0;
        w_frame_done  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_word_nxt    = '0;
                w_pos_row_nxt = '0;
                w_pos_col_nxt = '0;
                if (enable) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.mem_ack) begin
                    w_state_nxt = S_UNPACK;
                    w_k_nxt     = '0;
                    w_emit      = 1'b1;
                    w_code      = bus.mem_data[WORD_SIZE-1 -: ASCII_SIZE];
                    w_data_nxt  = bus.mem_data << ASCII_SIZE;
                end
            end
            S_UNPACK: begin
                if (r_k == K_W'(CPW - 1)) begin
                    if (r_word == WORD_W'(WORDS - 1)) begin
                        w_frame_done  = 1'b1;
                        w_word_nxt    = '0;
                        w_pos_row_nxt = '0;
                        w_pos_col_nxt = '0;
                        w_gap_nxt     = '0;
                        w_state_nxt   = S_GAP;
                    end else if (!enable) begin
                        w_word_nxt    = '0;
                        w_pos_row_nxt = '0;
                        w_pos_col_nxt = '0;
                        w_state_nxt   = S_IDLE;
                    end else begin
                        w_word_nxt  = r_word + WORD_W'(1);
                        w_state_nxt = S_REQ;
                    end
                end else begin
                    w_k_nxt    = r_k + K_W'(1);
                    w_emit     = 1'b1;
                    w_code     = r_data[WORD_SIZE-1 -: ASCII_SIZE];
                    w_data_nxt = r_data << ASCII_SIZE;
                end
            end
            S_GAP: begin
                if (r_gap == GAP_W'(GAP_LAST)) begin
                    w_state_nxt = enable ? S_REQ : S_IDLE;
                end else begin
                    w_gap_nxt = r_gap + GAP_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Screen position of the next character advances with every write.
        if (w_emit) begin
            if (r_pos_col == COL_W'(CHARS_HORZ - 1)) begin
                w_pos_col_nxt = '0;
                w_pos_row_nxt = (r_pos_row == ROW_W'(CHARS_VERT - 1)) ? '0 : r_pos_row + ROW_W'(1);
            end else begin
                w_pos_col_nxt = r_pos_col + COL_W'(1);
            end
        end
    end

    // Registered outputs derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_req    <= 1'b0;
            r_mem_addr   <= WORD_SIZE'(VGA_MEM_OFFSET);
            r_char_we    <= 1'b0;
            r_char_row   <= '0;
            r_char_col   <= '0;
            r_char_code  <= '0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_mem_req    <= (w_state_nxt == S_REQ);
            r_mem_addr   <= WORD_SIZE'(VGA_MEM_OFFSET) + WORD_SIZE'(w_word_nxt);
            r_char_we    <= w_emit;
            if (w_emit) begin
                r_char_row  <= r_pos_row;
                r_char_col  <= r_pos_col;
                r_char_code <= w_code;
            end
            r_frame_done <= w_frame_done;
            r_busy       <= (w_state_nxt != S_IDLE);
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.char_we   = r_char_we;
    assign bus.char_row  = r_char_row;
    assign bus.char_col  = r_char_col;
    assign bus.char_code = r_char_code;
    assign frame_done    = r_frame_done;
    assign busy          = r_busy;
endmodule

// File: tb/tb_char_buffer_fetch.sv
// Bench for char_buffer_fetch: randomized memory latency and contents, checked
// against a screen-layout model computed from word indices.
`timescale 1ns/1ps
module tb_char_buffer_fetch;
    localparam int unsigned WORD_SIZE   = 32;
    localparam int unsigned ASCII_SIZE  = 8;
    localparam int unsigned CHARS_HORZ  = 80;
    localparam int unsigned CHARS_VERT  = 30;
    localparam int unsigned OFFSET      = 32'h100;
    localparam int unsigned REFRESH_GAP = 4;
    localparam int          CPW         = WORD_SIZE / ASCII_SIZE;
    localparam int          WPR         = CHARS_HORZ / CPW;
    localparam int          WORDS       = CHARS_HORZ * CHARS_VERT / CPW;

    typedef struct { int row; int col; int code; int cyc; } wr_t;
    typedef struct { int addr; logic [31:0] data; } ack_t;
    typedef struct { int addr; int cyc; bit restart; } req_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic frame_done, busy;

    char_buffer_fetch_if #(.WORD_SIZE(WORD_SIZE), .ASCII_SIZE(ASCII_SIZE),
                           .CHARS_HORZ(CHARS_HORZ), .CHARS_VERT(CHARS_VERT)) bus ();

    char_buffer_fetch #(.WORD_SIZE(WORD_SIZE), .ASCII_SIZE(ASCII_SIZE),
                        .CHARS_HORZ(CHARS_HORZ), .CHARS_VERT(CHARS_VERT),
                        .VGA_MEM_OFFSET(OFFSET), .REFRESH_GAP(REFRESH_GAP)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_model [WORDS];
    wr_t  wrs[$];
    ack_t acks[$];
    req_t reqs[$];
    int   lat_mode = 0;
    int   cur_lat, wait_cnt, wcnt;
    bit   in_req = 1'b0;
    bit   restart_pending = 1'b1;
    logic [31:0] req_addr0;
    int   addr_unstable, req_drop, fd_count, fd_cyc, busy_bad;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder and output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        wr_t  w;
        ack_t a;
        req_t r;
        int   idx;
        bus.mem_ack  = 1'b0;
        bus.mem_data = $urandom;
        if (!rst_n) begin
            restart_pending = 1'b1;
            wcnt = 0;
        end
        if ((bus.mem_req || bus.char_we) && !busy) busy_bad++;
        if (frame_done) begin
            fd_count++;
            fd_cyc = cyc;
            restart_pending = 1'b1;
        end
        if (bus.char_we) begin
            w.row = int'(bus.char_row); w.col = int'(bus.char_col);
            w.code = int'(bus.char_code); w.cyc = cyc;
            wrs.push_back(w);
            wcnt++;
            if (wcnt == CPW) begin
                wcnt = 0;
                if (!enable) restart_pending = 1'b1;
            end
        end
        if (rst_n && bus.mem_req) begin
            if (!in_req) begin
                in_req = 1'b1;
                wait_cnt = 0;
                req_addr0 = bus.mem_addr;
                cur_lat = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
                r.addr = int'(bus.mem_addr); r.cyc = cyc; r.restart = restart_pending;
                reqs.push_back(r);
                restart_pending = 1'b0;
            end else if (bus.mem_addr !== req_addr0) begin
                addr_unstable++;
            end
            if (wait_cnt == cur_lat) begin
                idx = int'(bus.mem_addr) - int'(OFFSET);
                if (idx < 0 || idx >= WORDS) idx = 0;
                bus.mem_ack  = 1'b1;
                bus.mem_data = mem_model[idx];
                a.addr = int'(bus.mem_addr); a.data = mem_model[idx];
                acks.push_back(a);
                in_req = 1'b0;
            end else begin
                wait_cnt++;
            end
        end else begin
            if (in_req && rst_n) req_drop++;
            in_req = 1'b0;
        end
    end

    task automatic clear_logs();
        wrs.delete(); acks.delete(); reqs.delete();
        fd_count = 0; addr_unstable = 0; req_drop = 0; busy_bad = 0;
    endtask

    task automatic wait_for(input int nreq, input int nwr, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (reqs.size() >= nreq && wrs.size() >= nwr) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(output bit ok);
        int quiet = 0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            if (!busy && !bus.mem_req) quiet++; else quiet = 0;
            if (quiet >= 3) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        rst_n = 1'b0; enable = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_vec++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
        n_vec++; if (bus.mem_addr !== OFFSET) begin n_err++; $display("FAIL reset_mem_addr: got %h want %h", bus.mem_addr, OFFSET); end
        n_vec++; if (bus.char_we !== 1'b0) begin n_err++; $display("FAIL reset_char_we: got %b want 0", bus.char_we); end
        n_vec++; if (bus.char_row !== '0 || bus.char_col !== '0 || bus.char_code !== '0) begin
            n_err++; $display("FAIL reset_char_pos: got %0d/%0d/%h want 0/0/00", bus.char_row, bus.char_col, bus.char_code); end
        n_vec++; if (frame_done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL reset_flags: got fd=%b busy=%b want 0 0", frame_done, busy); end
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #2;
            if (bus.mem_req !== 1'b0 || busy !== 1'b0 || bus.char_we !== 1'b0 || frame_done !== 1'b0) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL idle_quiet: %0d active cycles want 0", bad); end
        n_vec++; if (bus.mem_addr !== OFFSET) begin n_err++; $display("FAIL idle_mem_addr: got %h want %h", bus.mem_addr, OFFSET); end
    endtask

    task automatic test_single_word();
        bit ok;
        mem_model[0] = 32'h41424344;
        lat_mode = 0;
        clear_logs();
        @(posedge clk); #2; enable = 1'b1;
        @(posedge clk); #2;
        n_vec++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== OFFSET) begin
            n_err++; $display("FAIL first_req: got req=%b addr=%h want 1 %h", bus.mem_req, bus.mem_addr, OFFSET); end
        wait_for(2, 0, 50, ok);
        enable = 1'b0;
        n_vec++; if (!ok) begin n_err++; $display("FAIL single_timeout: got %0d reqs want 2", reqs.size()); end
        wait_idle(ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL single_idle_timeout: busy=%b want 0", busy); end
        n_vec++; if (wrs.size() != 2 * CPW || reqs.size() != 2) begin
            n_err++; $display("FAIL single_counts: got %0d writes %0d reqs want 8 2", wrs.size(), reqs.size()); end
        if (wrs.size() >= 4 && reqs.size() >= 2) begin
            for (int k = 0; k < 4; k++) begin
                n_vec++;
                if (wrs[k].row != 0 || wrs[k].col != k || wrs[k].code != 'h41 + k || wrs[k].cyc != reqs[0].cyc + 1 + k) begin
                    n_err++; $display("FAIL single_write%0d: got (%0d,%0d,%h)@%0d want (0,%0d,%h)@%0d", k,
                        wrs[k].row, wrs[k].col, wrs[k].code, wrs[k].cyc, k, 'h41 + k, reqs[0].cyc + 1 + k);
                end
            end
            n_vec++; if (reqs[1].addr != OFFSET + 1 || reqs[1].cyc - reqs[0].cyc != CPW + 1) begin
                n_err++; $display("FAIL second_req: got addr=%h gap=%0d want %h %0d", reqs[1].addr,
                    reqs[1].cyc - reqs[0].cyc, OFFSET + 1, CPW + 1); end
        end
    endtask

    task automatic test_row_wrap();
        bit ok;
        int idx, k, ec;
        lat_mode = 3;
        clear_logs();
        enable = 1'b1;
        wait_for(21, 0, 400, ok);
        enable = 1'b0;
        n_vec++; if (!ok) begin n_err++; $display("FAIL wrap_timeout: got %0d reqs want 21", reqs.size()); end
        wait_idle(ok);
        n_vec++; if (acks.size() != 21 || wrs.size() != 84) begin
            n_err++; $display("FAIL wrap_counts: got %0d acks %0d writes want 21 84", acks.size(), wrs.size()); end
        if (wrs.size() >= 84 && reqs.size() >= 2) begin
            for (int i = 76; i < 81; i++) begin
                idx = i / CPW; k = i % CPW;
                ec = int'((mem_model[idx] >> (ASCII_SIZE * (CPW - 1 - k))) & 32'hFF);
                n_vec++;
                if (wrs[i].row != (i < 80 ? 0 : 1) || wrs[i].col != i % 80 || wrs[i].code != ec) begin
                    n_err++; $display("FAIL wrap_write%0d: got (%0d,%0d,%h) want (%0d,%0d,%h)", i,
                        wrs[i].row, wrs[i].col, wrs[i].code, i < 80 ? 0 : 1, i % 80, ec);
                end
            end
            n_vec++; if (reqs[1].cyc - reqs[0].cyc != 3 + CPW + 1) begin
                n_err++; $display("FAIL wrap_period: got %0d want %0d", reqs[1].cyc - reqs[0].cyc, 3 + CPW + 1); end
        end
        n_vec++; if (addr_unstable != 0 || req_drop != 0) begin
            n_err++; $display("FAIL wrap_hold: got unstable=%0d drops=%0d want 0 0", addr_unstable, req_drop); end
    endtask

    task automatic test_full_frame();
        bit ok;
        int bad, first_bad, nbefore, last_cyc, idx, k, ec;
        lat_mode = -1;
        clear_logs();
        enable = 1'b1;
        wait_for(WORDS + 1, 0, 8000, ok);
        enable = 1'b0;
        n_vec++; if (!ok) begin n_err++; $display("FAIL frame_timeout: got %0d reqs want %0d", reqs.size(), WORDS + 1); end
        wait_idle(ok);
        if (reqs.size() >= WORDS + 1 && wrs.size() >= WORDS * CPW) begin
            bad = 0; first_bad = -1;
            for (int i = 0; i < WORDS; i++)
                if (reqs[i].addr != int'(OFFSET) + i) begin bad++; if (first_bad < 0) first_bad = i; end
            n_vec++; if (bad != 0) begin n_err++; $display("FAIL frame_addrs: %0d bad, first idx %0d got %h want %h",
                bad, first_bad, reqs[first_bad].addr, int'(OFFSET) + first_bad); end
            bad = 0; first_bad = -1;
            for (int i = 0; i < WORDS * CPW; i++) begin
                idx = i / CPW; k = i % CPW;
                ec = int'((mem_model[idx] >> (ASCII_SIZE * (CPW - 1 - k))) & 32'hFF);
                if (wrs[i].row != idx / WPR || wrs[i].col != (idx % WPR) * CPW + k || wrs[i].code != ec) begin
                    bad++; if (first_bad < 0) first_bad = i;
                end
            end
            n_vec++; if (bad != 0) begin n_err++; $display("FAIL frame_writes: %0d bad, first idx %0d got (%0d,%0d,%h)",
                bad, first_bad, wrs[first_bad].row, wrs[first_bad].col, wrs[first_bad].code); end
            nbefore = 0; last_cyc = -1;
            foreach (wrs[i]) if (wrs[i].cyc < fd_cyc) begin nbefore++; last_cyc = wrs[i].cyc; end
            n_vec++; if (nbefore != WORDS * CPW || last_cyc != fd_cyc - 1) begin
                n_err++; $display("FAIL frame_write_count: got %0d last@%0d want %0d last@%0d", nbefore, last_cyc,
                    WORDS * CPW, fd_cyc - 1); end
            n_vec++; if (reqs[WORDS].addr != int'(OFFSET) || reqs[WORDS].cyc - fd_cyc != int'(REFRESH_GAP)) begin
                n_err++; $display("FAIL frame_restart: got addr=%h delay=%0d want %h %0d", reqs[WORDS].addr,
                    reqs[WORDS].cyc - fd_cyc, OFFSET, REFRESH_GAP); end
        end
        n_vec++; if (fd_count != 1) begin n_err++; $display("FAIL frame_done_count: got %0d want 1", fd_count); end
    endtask

    task automatic test_enable_drop();
        bit ok;
        lat_mode = 3;
        clear_logs();
        enable = 1'b1;
        wait_for(3, 0, 100, ok);
        enable = 1'b0;
        n_vec++; if (!ok || bus.mem_req !== 1'b1) begin
            n_err++; $display("FAIL drop_setup: got reqs=%0d req=%b want 3 1", reqs.size(), bus.mem_req); end
        wait_idle(ok);
        n_vec++; if (!ok || acks.size() != 3 || wrs.size() != 3 * CPW) begin
            n_err++; $display("FAIL drop_complete: got acks=%0d writes=%0d want 3 12", acks.size(), wrs.size()); end
        n_vec++; if (busy !== 1'b0 || bus.mem_req !== 1'b0 || bus.mem_addr !== OFFSET) begin
            n_err++; $display("FAIL drop_idle: got busy=%b req=%b addr=%h want 0 0 %h", busy, bus.mem_req, bus.mem_addr, OFFSET); end
        if (wrs.size() == 3 * CPW) begin
            n_vec++; if (wrs[11].row != 0 || wrs[11].col != 11) begin
                n_err++; $display("FAIL drop_last_write: got (%0d,%0d) want (0,11)", wrs[11].row, wrs[11].col); end
        end
        clear_logs();
        enable = 1'b1;
        wait_for(1, CPW, 50, ok);
        enable = 1'b0;
        n_vec++; if (!ok) begin n_err++; $display("FAIL reenable_timeout: got %0d writes want 4", wrs.size()); end
        if (ok) begin
            n_vec++; if (reqs[0].addr != int'(OFFSET) || wrs[0].row != 0 || wrs[0].col != 0 ||
                         wrs[0].code != int'(mem_model[0] >> 24)) begin
                n_err++; $display("FAIL reenable_start: got addr=%h (%0d,%0d,%h) want %h (0,0,%h)", reqs[0].addr,
                    wrs[0].row, wrs[0].col, wrs[0].code, OFFSET, mem_model[0] >> 24); end
        end
        wait_idle(ok);
    endtask

    task automatic test_async_reset();
        bit ok;
        int seen = 0;
        int sz0;
        lat_mode = 0;
        clear_logs();
        enable = 1'b1;
        for (int i = 0; i < 50 && seen < 3; i++) begin
            @(posedge clk); #2;
            if (bus.char_we === 1'b1) seen++;
        end
        n_vec++; if (seen != 3) begin n_err++; $display("FAIL areset_setup: got %0d writes want 3", seen); end
        rst_n = 1'b0; enable = 1'b0;
        #1;
        n_vec++; if (bus.char_we !== 1'b0 || bus.mem_req !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL areset_immediate: got we=%b req=%b busy=%b want 0 0 0", bus.char_we, bus.mem_req, busy); end
        sz0 = wrs.size();
        repeat (5) @(posedge clk);
        #2;
        n_vec++; if (wrs.size() != sz0 || bus.mem_addr !== OFFSET) begin
            n_err++; $display("FAIL areset_hold: got %0d writes addr=%h want %0d %h", wrs.size(), bus.mem_addr, sz0, OFFSET); end
        rst_n = 1'b1;
        clear_logs();
        @(posedge clk); #2;
        enable = 1'b1;
        wait_for(1, CPW, 50, ok);
        enable = 1'b0;
        n_vec++; if (!ok) begin n_err++; $display("FAIL areset_restart_timeout: got %0d writes want 4", wrs.size()); end
        if (ok) begin
            for (int k = 0; k < CPW; k++) begin
                n_vec++;
                if (wrs[k].row != 0 || wrs[k].col != k ||
                    wrs[k].code != int'((mem_model[0] >> (ASCII_SIZE * (CPW - 1 - k))) & 32'hFF) || reqs[0].addr != int'(OFFSET)) begin
                    n_err++; $display("FAIL areset_restart%0d: got addr=%h (%0d,%0d,%h) want %h (0,%0d)", k, reqs[0].addr,
                        wrs[k].row, wrs[k].col, wrs[k].code, OFFSET, k);
                end
            end
        end
        wait_idle(ok);
    endtask

    task automatic test_random_enable();
        bit ok;
        int bad, first_bad, exp_idx, idx, k, ec;
        lat_mode = -1;
        clear_logs();
        enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            if ($urandom_range(0, 99) < 3) enable = ~enable;
        end
        enable = 1'b0;
        wait_idle(ok);
        n_vec++; if (!ok || reqs.size() != acks.size() || wrs.size() != CPW * acks.size()) begin
            n_err++; $display("FAIL rand_counts: got reqs=%0d acks=%0d writes=%0d want reqs=acks writes=4*acks",
                reqs.size(), acks.size(), wrs.size()); end
        bad = 0; first_bad = -1; exp_idx = 0;
        foreach (reqs[i]) begin
            exp_idx = reqs[i].restart ? 0 : exp_idx + 1;
            if (reqs[i].addr != int'(OFFSET) + exp_idx) begin bad++; if (first_bad < 0) first_bad = i; end
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL rand_addrs: %0d bad, first req %0d got %h", bad, first_bad,
            reqs[first_bad].addr); end
        bad = 0; first_bad = -1;
        if (wrs.size() == CPW * acks.size()) begin
            foreach (wrs[i]) begin
                idx = acks[i / CPW].addr - int'(OFFSET); k = i % CPW;
                ec = int'((acks[i / CPW].data >> (ASCII_SIZE * (CPW - 1 - k))) & 32'hFF);
                if (wrs[i].row != idx / WPR || wrs[i].col != (idx % WPR) * CPW + k || wrs[i].code != ec) begin
                    bad++; if (first_bad < 0) first_bad = i;
                end
            end
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL rand_writes: %0d bad, first idx %0d got (%0d,%0d,%h)",
            bad, first_bad, wrs[first_bad].row, wrs[first_bad].col, wrs[first_bad].code); end
        n_vec++; if (addr_unstable != 0 || req_drop != 0 || busy_bad != 0) begin
            n_err++; $display("FAIL rand_protocol: got unstable=%0d drops=%0d busy_bad=%0d want 0 0 0",
                addr_unstable, req_drop, busy_bad); end
    endtask

    initial begin
        foreach (mem_model[i]) mem_model[i] = $urandom;
        test_reset();
        test_single_word();
        test_row_wrap();
        test_full_frame();
        test_enable_drop();
        test_async_reset();
        test_random_enable();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
